fma_align_pipe: RTL and testbench

//  Pipelined addend aligner for the FMA datapath; parametrised successor of the combinational aligner.

---
 rtl/fma_align_pipe_if.sv | 39 +++
 rtl/fma_align_pipe.sv | 122 ++++++++++++
 tb/tb_fma_align_pipe.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_align_pipe_if.sv
// Operand-in / aligned-addend-out bundle for the FMA addend aligner.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operation side and the result side.
interface fma_align_pipe_if #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23,
    parameter int TAG_WIDTH = 4
);
    localparam int AW  = 3 * (SIG_WIDTH + 1) + 7;
    localparam int SHW = $clog2(AW);

    logic                 in_valid;
    logic                 in_ready;
    logic [EXP_WIDTH-1:0] exp_a;
    logic [EXP_WIDTH-1:0] exp_b;
    logic [EXP_WIDTH-1:0] exp_c;
    logic [SIG_WIDTH:0]   sig_c;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        c_aligned;
    logic                 sticky;
    logic [SHW-1:0]       shamt;
    logic                 c_dom;
    logic [TAG_WIDTH-1:0] out_tag;

    // Producer of operations / consumer of aligned results
    modport master (
        output in_valid, exp_a, exp_b, exp_c, sig_c, in_tag, out_ready,
        input  in_ready, out_valid, c_aligned, sticky, shamt, c_dom, out_tag
    );

    // The aligner itself
    modport slave (
        input  in_valid, exp_a, exp_b, exp_c, sig_c, in_tag, out_ready,
        output in_ready, out_valid, c_aligned, sticky, shamt, c_dom, out_tag
    );
endinterface

// File: rtl/fma_align_pipe.sv
// Pipelined FMA addend aligner: clamped shift from exponents, then right-shift of C with exact sticky.
// Latency: 2 cycles (S1 exponent arithmetic, S2 shift), 1 op/cycle throughput.
// Backpressure: S2 holds while out_valid && !out_ready; in_ready = !s1_valid || S2 advancing.
module fma_align_pipe #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23,
    parameter int BIAS      = 127,
    parameter int TAG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    fma_align_pipe_if.slave  io
);
    localparam int SW1    = SIG_WIDTH + 1;
    localparam int AW     = 3 * SW1 + 7;
    localparam int OFFSET = SIG_WIDTH + 4;
    localparam int MAXSH  = AW - 1;
    localparam int SHW    = $clog2(AW);
    localparam int DW     = EXP_WIDTH + 3;
    localparam int RW     = EXP_WIDTH + 4;
    localparam int LOW    = 2 * SW1 + 6;

    typedef struct packed {
        logic [SHW-1:0]       shamt;
        logic                 c_dom;
        logic [SIG_WIDTH:0]   sig;
        logic [TAG_WIDTH-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [AW-1:0]        c_aligned;
        logic                 sticky;
        logic [SHW-1:0]       shamt;
        logic                 c_dom;
        logic [TAG_WIDTH-1:0] tag;
    } s2_t;

    logic              s1_valid;
    logic              s2_valid;
    logic              s2_adv;
    logic              in_rdy;
    s1_t               s1_d;
    s1_t               s1_q;
    s2_t               s2_d;
    s2_t               s2_q;
    logic signed [DW-1:0] d;
    logic signed [RW-1:0] raw;
    logic [AW-1:0]     window;
    logic [AW-1:0]     below;

    // S1 can move whenever S2 moves; an empty S2 always moves, so no separate term is needed
    assign s2_adv      = !s2_valid || io.out_ready;
    assign in_rdy      = !s1_valid || s2_adv;
    assign io.in_ready = in_rdy;

    // Unbiased product exponent minus addend exponent; zero-extended operands keep it exact
    assign d   = $signed({3'b000, io.exp_a}) + $signed({3'b000, io.exp_b})
               - $signed(DW'(BIAS)) - $signed({3'b000, io.exp_c});
    assign raw = $signed(RW'(OFFSET)) + RW'(d);

    // Clamp the raw shift into [0, MAXSH]; a non-positive shift means C dominates the product
    always_comb begin
        s1_d       = '0;
        s1_d.sig   = io.sig_c;
        s1_d.tag   = io.in_tag;
        if (raw[RW-1] || raw == '0) begin
            s1_d.shamt = '0;
            s1_d.c_dom = 1'b1;
        end else if (raw >= $signed(RW'(MAXSH))) begin
            s1_d.shamt = SHW'(MAXSH);
        end else begin
            s1_d.shamt = SHW'(raw);
        end
    end

    // C sits just below the guard zero at the top of the window; sticky ORs everything pushed below bit 0
    assign window = {1'b0, s1_q.sig, {LOW{1'b0}}};
    assign below  = ~({AW{1'b1}} << s1_q.shamt);

    // Shift result and sideband for the S2 register
    always_comb begin
        s2_d           = '0;
        s2_d.c_aligned = window >> s1_q.shamt;
        s2_d.sticky    = |(window & below);
        s2_d.shamt     = s1_q.shamt;
        s2_d.c_dom     = s1_q.c_dom;
        s2_d.tag       = s1_q.tag;
    end

    // S1 register: captures an operation whenever it has room
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_rdy) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // S2 register: payload only reloads on a real transfer so stalled outputs stay put
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign io.out_valid = s2_valid;
    assign io.c_aligned = s2_q.c_aligned;
    assign io.sticky    = s2_q.sticky;
    assign io.shamt     = s2_q.shamt;
    assign io.c_dom     = s2_q.c_dom;
    assign io.out_tag   = s2_q.tag;
endmodule

// File: tb/tb_fma_align_pipe.sv
// Bench for fma_align_pipe: directed vector table, stall/flush sequences, randomized scoreboard run.
// Latency: checks the 2-cycle result timing on the table vectors.
// Backpressure: drives patterned and random out_ready, checks hold-stability and in_ready.
module tb_fma_align_pipe;
    localparam int EW   = 8;
    localparam int SW   = 23;
    localparam int BIAS = 127;
    localparam int TW   = 4;
    localparam int AW   = 79;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fma_align_pipe_if #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

    fma_align_pipe #(.EXP_WIDTH(EW), .SIG_WIDTH(SW), .BIAS(BIAS), .TAG_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [6:0]    shamt;
        logic          c_dom;
        logic          sticky;
        logic [AW-1:0] al;
        logic [TW-1:0] tag;
    } res_t;

    typedef struct {
        logic [7:0]    ea, eb, ec;
        logic [23:0]   sig;
        logic [6:0]    shamt;
        logic          c_dom;
        logic          sticky;
        logic [AW-1:0] al;
    } vec_t;

    int   checks  = 0;
    int   errors  = 0;
    int   retired = 0;
    res_t sb[$];
    logic stalled = 1'b0;
    res_t prev;
    res_t e;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: value semantics of the alignment (integer shift amount, divide/remainder by 2^shamt)
    function automatic res_t model(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                                   input logic [23:0] sig, input logic [TW-1:0] tag);
        res_t         r;
        int           raw;
        int           sh;
        logic [127:0] win;
        logic [127:0] pw;
        raw     = 27 + int'(ea) + int'(eb) - 127 - int'(ec);
        r.c_dom = (raw <= 0);
        if (raw <= 0)       sh = 0;
        else if (raw >= 78) sh = 78;
        else                sh = raw;
        win      = 128'(sig) * (128'd1 << 54);
        pw       = 128'd1 << sh;
        r.al     = AW'(win / pw);
        r.sticky = ((win % pw) != 128'd0);
        r.shamt  = 7'(sh);
        r.tag    = tag;
        return r;
    endfunction

    function automatic vec_t mk(input int ea, input int eb, input int ec, input logic [23:0] sig,
                                input int sh, input logic dom, input logic stk, input logic [AW-1:0] al);
        vec_t v;
        v.ea = 8'(ea); v.eb = 8'(eb); v.ec = 8'(ec); v.sig = sig;
        v.shamt = 7'(sh); v.c_dom = dom; v.sticky = stk; v.al = al;
        return v;
    endfunction

    task automatic drive(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                         input logic [23:0] sig, input logic [TW-1:0] tag);
        bus.exp_a = ea; bus.exp_b = eb; bus.exp_c = ec; bus.sig_c = sig; bus.in_tag = tag;
    endtask

    task automatic rand_op(input logic [TW-1:0] tag);
        logic [7:0]  ea, eb, ec;
        logic [23:0] sig;
        ea  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(90, 180)) : 8'($urandom_range(0, 255));
        eb  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(90, 180)) : 8'($urandom_range(0, 255));
        ec  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(60, 200)) : 8'($urandom_range(0, 255));
        sig = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
        drive(ea, eb, ec, sig, tag);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, 128'(sb.size()), 128'd0);
    endtask

    // Scoreboard monitor, sampled mid-cycle when all handshake signals are settled
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            chk("in_ready", 128'(bus.in_ready), 128'((sb.size() < 2) || bus.out_ready));
            if (stalled) begin
                chk("hold_valid",   128'(bus.out_valid), 128'd1);
                chk("hold_aligned", 128'(bus.c_aligned), 128'(prev.al));
                chk("hold_sticky",  128'(bus.sticky),    128'(prev.sticky));
                chk("hold_shamt",   128'(bus.shamt),     128'(prev.shamt));
                chk("hold_cdom",    128'(bus.c_dom),     128'(prev.c_dom));
                chk("hold_tag",     128'(bus.out_tag),   128'(prev.tag));
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual=valid required=idle");
                end else if (bus.out_ready) begin
                    e = sb.pop_front();
                    chk("sb_aligned", 128'(bus.c_aligned), 128'(e.al));
                    chk("sb_sticky",  128'(bus.sticky),    128'(e.sticky));
                    chk("sb_shamt",   128'(bus.shamt),     128'(e.shamt));
                    chk("sb_cdom",    128'(bus.c_dom),     128'(e.c_dom));
                    chk("sb_tag",     128'(bus.out_tag),   128'(e.tag));
                    retired++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.exp_a, bus.exp_b, bus.exp_c, bus.sig_c, bus.in_tag));
            end
            stalled     = bus.out_valid && !bus.out_ready;
            prev.al     = bus.c_aligned;
            prev.sticky = bus.sticky;
            prev.shamt  = bus.shamt;
            prev.c_dom  = bus.c_dom;
            prev.tag    = bus.out_tag;
        end
    end

    initial begin
        vec_t tbl[10];
        logic or_pat[6];
        int   lat;
        int   n;
        int   cyc;
        int   full_seen;
        int   base;
        logic fire;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(8'd0, 8'd0, 8'd0, 24'd0, 4'd0);

        tbl[0] = mk(127, 127, 127, 24'h800000, 27, 1'b0, 1'b0, 79'd1 << 50);
        tbl[1] = mk(200, 200,   1, 24'hC00001, 78, 1'b0, 1'b1, 79'd0);
        tbl[2] = mk(  1,   1, 254, 24'h800000,  0, 1'b1, 1'b0, 79'd1 << 77);
        tbl[3] = mk(155, 127, 127, 24'h000001, 55, 1'b0, 1'b1, 79'd0);
        tbl[4] = mk(154, 127, 127, 24'h000001, 54, 1'b0, 1'b0, 79'd1);
        tbl[5] = mk(127, 127, 127, 24'h000000, 27, 1'b0, 1'b0, 79'd0);
        tbl[6] = mk(100, 127, 127, 24'hFFFFFF,  0, 1'b1, 1'b0, 79'hFFFFFF << 54);
        tbl[7] = mk(101, 127, 127, 24'hFFFFFF,  1, 1'b0, 1'b0, 79'hFFFFFF << 53);
        tbl[8] = mk(177, 127, 127, 24'hC00000, 77, 1'b0, 1'b1, 79'd1);
        tbl[9] = mk(178, 127, 127, 24'hC00000, 78, 1'b0, 1'b1, 79'd0);
        or_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_aligned",   128'(bus.c_aligned), 128'd0);
        chk("rst_sticky",    128'(bus.sticky),    128'd0);
        chk("rst_shamt",     128'(bus.shamt),     128'd0);
        chk("rst_cdom",      128'(bus.c_dom),     128'd0);
        chk("rst_tag",       128'(bus.out_tag),   128'd0);
        @(posedge clk); #1;
        chk("rst_in_ready",  128'(bus.in_ready),  128'd1);

        // Directed table, one op at a time, checking 2-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].sig, 4'(i));
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'd2);
            chk($sformatf("tbl%0d_shamt", i),   128'(bus.shamt),     128'(tbl[i].shamt));
            chk($sformatf("tbl%0d_cdom", i),    128'(bus.c_dom),     128'(tbl[i].c_dom));
            chk($sformatf("tbl%0d_sticky", i),  128'(bus.sticky),    128'(tbl[i].sticky));
            chk($sformatf("tbl%0d_aligned", i), 128'(bus.c_aligned), 128'(tbl[i].al));
            chk($sformatf("tbl%0d_tag", i),     128'(bus.out_tag),   128'(i));
        end
        @(posedge clk); #1;

        // Six tagged ops against a 1,0,0,1,0,1 out_ready pattern
        base      = retired;
        n         = 0;
        cyc       = 0;
        full_seen = 0;
        rand_op(4'd1);
        bus.in_valid  = 1'b1;
        bus.out_ready = or_pat[0];
        while (n < 6 && cyc < 200) begin
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            if (!bus.in_ready) full_seen++;
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                n++;
                if (n < 6) rand_op(4'(n + 1));
                else       bus.in_valid = 1'b0;
            end
            bus.out_ready = or_pat[cyc % 6];
        end
        chk("t5_all_accepted", 128'(n), 128'd6);
        chk("t5_backpressure", 128'(full_seen > 0), 128'd1);
        drain("t5_drain");
        chk("t5_retired", 128'(retired - base), 128'd6);

        // Reset with two operations in flight
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(8'd200, 8'd200, 8'd1, 24'hC00001, 4'd9);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(8'd1, 8'd1, 8'd254, 24'h800000, 4'd10);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("t6_inflight", 128'(bus.out_valid), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_flush", 128'(bus.out_valid), 128'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_no_ghost", 128'(bus.out_valid), 128'd0);
        end
        drive(8'd127, 8'd127, 8'd127, 24'h800000, 4'd12);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t6_latency", 128'(lat), 128'd2);
        chk("t6_tag",     128'(bus.out_tag),   128'd12);
        chk("t6_shamt",   128'(bus.shamt),     128'd27);
        chk("t6_aligned", 128'(bus.c_aligned), 128'(79'd1 << 50));
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        rand_op(4'($urandom));
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire || !bus.in_valid) begin
                rand_op(4'($urandom));
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
